incoming_response_buffer: RTL and testbench
===========================================

Name: incoming_response_buffer

Overview:
- DEPTH-entry FIFO for AXI R beats on the incoming side of the reorder path.
- Accepts R beats from the AXI slave on r_in and hands them, oldest first, to the r ordering unit on r_out.
- Is the return-direction counterpart of the outgoing AR buffer.
- Optional store-and-forward mode releases a burst only once its RLAST beat is stored; full-buffer and streaming rules guarantee forward progress.

Parameters:
- ID_WIDTH, 4, RID width.
- DATA_WIDTH, 64, RDATA width.
- RESP_WIDTH, 2, RRESP width.
- DEPTH, 8, number of beat entries; need not be a power of 2, minimum 2.
- STORE_AND_FWD, 1, 1 = gate r_out.valid on a complete burst being stored; 0 = cut-through.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r_in (r_if.receiver): id in ID_WIDTH; data in DATA_WIDTH; resp in RESP_WIDTH; last in 1; valid in 1; ready out 1. R beats from the AXI slave.
- r_out (r_if.sender): id out ID_WIDTH; data out DATA_WIDTH; resp out RESP_WIDTH; last out 1; valid out 1; ready in 1. R beats to the r ordering unit.
- count  out  CNT_W=$clog2(DEPTH+1)  number of stored beats.
- bursts_stored  out  CNT_W  number of stored beats with last=1.

Behaviour:
- Reset (rst_n low, async): wr_ptr, rd_ptr, count, bursts_stored and streaming_q are cleared to 0. r_out.valid=0. r_in.ready=0 while rst_n is low. All stored contents are discarded; storage is not cleared. Reset mid-burst drops partial bursts with no further output.
- r_in.ready = ~full & rst_n, where full = (count==DEPTH).
- push = r_in.valid & r_in.ready.
- pop = r_out.valid & r_out.ready.
- Push writes {id,data,resp,last} to mem[wr_ptr].
- Pointers advance by 1 and wrap from DEPTH-1 to 0; no power-of-2 masking.
- count:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push and pop; both pointers advance.
- bursts_stored:
  - +1 on push of a last beat; -1 on pop of a last beat.
  - Unchanged when both occur in the same cycle.
- r_out payload = mem[rd_ptr], combinational from registered state. There is no input-to-output bypass: minimum latency is 1 cycle (beat pushed at edge N is visible on r_out after edge N).
- Payload and valid hold stable while r_out.valid & ~r_out.ready.
- r_out.valid:
  - STORE_AND_FWD=0: valid = ~empty.
  - STORE_AND_FWD=1: valid = ~empty & ((bursts_stored!=0) | full | streaming_q).
- streaming_q (STORE_AND_FWD=1 only):
  - Set on pop of a beat with last=0.
  - Cleared on pop of a beat with last=1.
  - Otherwise holds.
- Once the head burst starts emitting, its remaining beats are released as they arrive. A burst longer than DEPTH drains via the full path and never deadlocks.
- The valid-without-handshake-never-drops property holds: each enabling term is cleared only by a pop or can't clear while valid waits. full cannot clear without a pop, because ready=0 blocks pushes.
- Ordering: strict FIFO; no reordering by id.

Test Plan:
- Reset: hold rst_n=0 with r_in.valid=1 -> r_in.ready=0, r_out.valid=0, count=0. Release -> r_in.ready=1 next cycle; no beat was captured.
- Store-and-forward, STORE_AND_FWD=1, r_out.ready=1:
  - Stimulus: push id=2 beats data 0xA0, 0xA1, 0xA2(last) on consecutive cycles.
  - r_out.valid stays 0 until the cycle after the 0xA2 push.
  - Then 0xA0, 0xA1, 0xA2 come out on 3 consecutive cycles.
  - bursts_stored goes 0->1->0; count returns to 0.
- Full/long burst, r_out.ready=0:
  - Stimulus: push 8 beats, last=0.
  - Required: count=8, r_in.ready=0, r_out.valid=1 (full term) with head data stable.
  - Set ready=1 for 1 cycle -> streaming_q=1, r_in.ready=1, and beat 9 (last=1) accepted.
  - All 9 beats out in order; streaming_q=0 after the last beat.
- Simultaneous push/pop with wrap:
  - Stimulus: hold count=4, then stream 20 beats with valid=ready=1 every cycle.
  - count stays 4 throughout.
  - Pointers wrap 7->0 multiple times; output sequence equals input sequence exactly, including resp=2'b10 on beat 13.
- Cut-through, STORE_AND_FWD=0: push a single beat last=0 -> r_out.valid=1 on the next cycle; bursts_stored=0.
- Reset mid-operation: 5 beats stored (1 complete burst), assert rst_n=0 for 1 cycle -> count=0, bursts_stored=0, r_out.valid=0 immediately. The next pushed beat is the first beat out.

Source files
------------

// File: rtl/incoming_response_buffer_if.sv
// AXI R-channel beat bundle shared by both sides of the incoming response buffer.
//   sender   : drives id/data/resp/last/valid, samples ready
//   receiver : samples id/data/resp/last/valid, drives ready
//   master/slave are aliases of sender/receiver for bus-style naming.
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport sender   (output id, data, resp, last, valid, input  ready);
  modport receiver (input  id, data, resp, last, valid, output ready);
  modport master   (output id, data, resp, last, valid, input  ready);
  modport slave    (input  id, data, resp, last, valid, output ready);
endinterface

// File: rtl/incoming_response_buffer.sv
// DEPTH-entry FIFO for AXI R beats on the return side of the reorder path.
// Beats from the AXI slave arrive on r_in and leave oldest-first on r_out.
// With STORE_AND_FWD=1 a burst is held back until its RLAST beat is stored,
// unless the buffer is full or the head burst has already started emitting.
//   clk, rst_n    : clock, asynchronous active-low reset
//   r_in          : R beats in (receiver side, drives ready)
//   r_out         : R beats out (sender side, payload from registered state)
//   count         : number of stored beats
//   bursts_stored : number of stored beats with last=1
module incoming_response_buffer #(
  parameter int ID_WIDTH      = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int RESP_WIDTH    = 2,
  parameter int DEPTH         = 8,
  parameter bit STORE_AND_FWD = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  r_if.receiver                        r_in,
  r_if.sender                          r_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   bursts_stored
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
  } beat_t;

  beat_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, bursts_q, bursts_d;
  logic             streaming_q, streaming_d;

  logic  full, empty, push, pop, out_valid;
  beat_t head, in_beat;

  // Wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    head       = mem_q[rd_ptr_q];
    in_beat    = '{id: r_in.id, data: r_in.data, resp: r_in.resp, last: r_in.last};
    // ready is forced low during reset so nothing is captured while rst_n is low.
    r_in.ready = ~full & rst_n;
    push       = r_in.valid & r_in.ready;
    // Every enabling term only clears on a pop (full can't clear without one
    // because ready=0 blocks pushes), so valid never drops without a handshake.
    if (STORE_AND_FWD) out_valid = ~empty & ((bursts_q != '0) | full | streaming_q);
    else               out_valid = ~empty;
    pop         = out_valid & r_out.ready;
    r_out.valid = out_valid;
    r_out.id    = head.id;
    r_out.data  = head.data;
    r_out.resp  = head.resp;
    r_out.last  = head.last;
  end

  always_comb begin
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    bursts_d    = bursts_q;
    streaming_d = streaming_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
    case ({push & r_in.last, pop & head.last})
      2'b10:   bursts_d = bursts_q + 1'b1;
      2'b01:   bursts_d = bursts_q - 1'b1;
      default: ;
    endcase
    // Once the head burst has emitted a beat, its remaining beats stream
    // through as they arrive; the last beat out closes the window.
    if (STORE_AND_FWD && pop) streaming_d = ~head.last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bursts_q    <= '0;
      streaming_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bursts_q    <= bursts_d;
      streaming_q <= streaming_d;
    end
  end

  // Storage is not reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_beat;
  end

  assign count         = count_q;
  assign bursts_stored = bursts_q;
endmodule

// File: tb/tb_incoming_response_buffer.sv
module tb_incoming_response_buffer;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic        iv;
    logic [63:0] data;
    logic        last;
    logic        ordy;
    logic        e_valid;
    logic [63:0] e_data;
    int          e_cnt;
    int          e_bur;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r_if in_if ();
  r_if out_if ();
  r_if ct_in ();
  r_if ct_out ();
  logic [3:0] count, bursts, ct_count, ct_bursts;

  incoming_response_buffer #(.DEPTH(DEPTH), .STORE_AND_FWD(1)) dut (
    .clk(clk), .rst_n(rst_n), .r_in(in_if), .r_out(out_if),
    .count(count), .bursts_stored(bursts));

  incoming_response_buffer #(.DEPTH(DEPTH), .STORE_AND_FWD(0)) dut_ct (
    .clk(clk), .rst_n(rst_n), .r_in(ct_in), .r_out(ct_out),
    .count(ct_count), .bursts_stored(ct_bursts));

  // Reference model: a queue of stored beats plus "head burst has started".
  beat_t mq[$];
  bit    m_stream;
  bit    m_push, m_pop;
  beat_t m_in;
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int m_lasts();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    return rst_n && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_valid();
    return (mq.size() != 0) && (m_lasts() != 0 || mq.size() == DEPTH || m_stream);
  endfunction

  function automatic beat_t dut_head();
    return '{id: out_if.id, data: out_if.data, resp: out_if.resp, last: out_if.last};
  endfunction

  // Entered just after a negedge; drives inputs then settles.
  task automatic apply(input logic iv, input beat_t b, input logic ordy);
    in_if.valid = iv;
    in_if.id    = b.id;
    in_if.data  = b.data;
    in_if.resp  = b.resp;
    in_if.last  = b.last;
    out_if.ready = ordy;
    m_in = b;
    #1;
    m_push = iv && m_ready();
    m_pop  = m_valid() && ordy;
  endtask

  task automatic model_check();
    chk("in_ready", in_if.ready, m_ready());
    chk("out_valid", out_if.valid, m_valid());
    if (m_valid()) chk("head", dut_head(), mq[0]);
    chk("count", count, mq.size());
    chk("bursts", bursts, m_lasts());
  endtask

  task automatic advance();
    beat_t h;
    @(posedge clk);
    if (rst_n) begin
      if (m_pop) begin
        h = mq.pop_front();
        m_stream = !h.last;
      end
      if (m_push) mq.push_back(m_in);
    end
    @(negedge clk);
  endtask

  task automatic step(input logic iv, input beat_t b, input logic ordy);
    apply(iv, b, ordy);
    model_check();
    advance();
  endtask

  task automatic drain();
    beat_t z = '0;
    for (int i = 0; i < 40 && mq.size() != 0; i++) step(1'b0, z, 1'b1);
    chk("drain_timeout", mq.size(), 0);
  endtask

  function automatic beat_t mk(input logic [3:0] id, input logic [63:0] d,
                               input logic [1:0] r, input logic l);
    return '{id: id, data: d, resp: r, last: l};
  endfunction

  vec_t tbl[7];

  initial begin
    beat_t z = '0;
    beat_t b;
    int k;
    // SAF burst: three beats, released only after the RLAST beat is stored.
    tbl[0] = '{1'b1, 64'hA0, 1'b0, 1'b1, 1'b0, 64'h0,  0, 0};
    tbl[1] = '{1'b1, 64'hA1, 1'b0, 1'b1, 1'b0, 64'h0,  1, 0};
    tbl[2] = '{1'b1, 64'hA2, 1'b1, 1'b1, 1'b0, 64'h0,  2, 0};
    tbl[3] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'hA0, 3, 1};
    tbl[4] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'hA1, 2, 1};
    tbl[5] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'hA2, 1, 1};
    tbl[6] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  0, 0};

    in_if.valid = 1'b1; in_if.id = '0; in_if.data = '0; in_if.resp = '0; in_if.last = 1'b0;
    out_if.ready = 1'b0;
    ct_in.valid = 1'b0; ct_in.id = '0; ct_in.data = '0; ct_in.resp = '0; ct_in.last = 1'b0;
    ct_out.ready = 1'b0;
    m_stream = 0;

    // Reset held with valid asserted: nothing accepted.
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_if.ready, 0);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_count", count, 0);
    chk("rst_bursts", bursts, 0);
    in_if.valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_if.ready, 1);
    @(negedge clk);
    step(1'b0, z, 1'b0);

    // Table-driven store-and-forward burst.
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].iv, mk(4'd2, tbl[i].data, 2'b00, tbl[i].last), tbl[i].ordy);
      model_check();
      chk($sformatf("tbl%0d_valid", i), out_if.valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), out_if.data, tbl[i].e_data);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_bursts", i), bursts, tbl[i].e_bur);
      advance();
    end

    // Long burst: fill with last=0, released through the full term.
    for (int i = 0; i < DEPTH; i++) step(1'b1, mk(4'd5, 64'h100 + i, 2'b00, 1'b0), 1'b0);
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, z, 1'b0);
      model_check();
      chk("full_count", count, DEPTH);
      chk("full_in_ready", in_if.ready, 0);
      chk("full_valid", out_if.valid, 1);
      chk("full_head_stable", out_if.data, 64'h100);
      advance();
    end
    b = mk(4'd5, 64'h108, 2'b00, 1'b1);
    step(1'b1, b, 1'b1);                 // pop one; beat 9 blocked (full)
    apply(1'b1, b, 1'b0);
    model_check();
    chk("stream_in_ready", in_if.ready, 1);
    chk("stream_valid", out_if.valid, 1);
    chk("stream_count", count, DEPTH - 1);
    advance();
    chk("beat9_count", count, DEPTH);
    drain();
    // Streaming window closed: a lone non-last beat must be held.
    step(1'b1, mk(4'd1, 64'h55, 2'b00, 1'b0), 1'b1);
    apply(1'b0, z, 1'b1);
    model_check();
    chk("stream_cleared", out_if.valid, 0);
    advance();
    step(1'b1, mk(4'd1, 64'h56, 2'b00, 1'b1), 1'b1);
    drain();

    // Simultaneous push/pop with pointer wrap, count held at 4.
    for (int i = 0; i < 4; i++) step(1'b1, mk(4'(i), 64'h200 + i, 2'b01, 1'b1), 1'b0);
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, mk(4'(i + 4), 64'h300 + i, (i == 13) ? 2'b10 : 2'b00, 1'b1), 1'b1);
      model_check();
      chk("wrap_count", count, 4);
      advance();
    end
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      b = mk(4'($urandom), {$urandom, $urandom}, 2'($urandom), ($urandom % 4) == 0);
      step(($urandom % 4) != 0, b, ($urandom % 3) != 0);
    end
    step(1'b1, mk(4'd9, 64'h77, 2'b00, 1'b1), 1'b0);
    k = 0;
    while (!m_push && k < 20) begin
      step(1'b1, mk(4'd9, 64'h77, 2'b00, 1'b1), 1'b1);
      k++;
    end
    drain();

    // Reset mid-operation with 5 beats (one complete burst) stored.
    for (int i = 0; i < 5; i++) step(1'b1, mk(4'd3, 64'h400 + i, 2'b00, i == 2), 1'b0);
    apply(1'b0, z, 1'b0);
    model_check();
    rst_n = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_bursts", bursts, 0);
    chk("mrst_valid", out_if.valid, 0);
    chk("mrst_in_ready", in_if.ready, 0);
    mq.delete();
    m_stream = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, mk(4'd6, 64'hBEEF, 2'b11, 1'b1), 1'b1);
    apply(1'b0, z, 1'b1);
    model_check();
    chk("mrst_first_out", out_if.data, 64'hBEEF);
    advance();
    drain();

    // Cut-through instance: a lone non-last beat is visible the next cycle.
    ct_in.valid = 1'b1; ct_in.id = 4'd7; ct_in.data = 64'hC0; ct_in.last = 1'b0;
    @(negedge clk);
    ct_in.id = 4'd7; ct_in.data = 64'hC1;
    #1;
    chk("ct_valid", ct_out.valid, 1);
    chk("ct_data", ct_out.data, 64'hC0);
    chk("ct_bursts", ct_bursts, 0);
    chk("ct_count", ct_count, 1);
    @(negedge clk);
    ct_in.valid = 1'b0;
    #1;
    chk("ct_hold", ct_out.data, 64'hC0);
    chk("ct_count2", ct_count, 2);
    ct_out.ready = 1'b1;
    @(negedge clk);
    #1;
    chk("ct_next", ct_out.data, 64'hC1);
    @(negedge clk);
    #1;
    chk("ct_empty", ct_out.valid, 0);
    chk("ct_count0", ct_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
